cpu_reg_file_sb: RTL and testbench

CPU_REG_FILE_SB -- requirements
Module: cpu_reg_file_sb

---
 rtl/cpu_pkg.sv | 13 +
 rtl/cpu_reg_file_read_port.sv | 51 +++++
 rtl/cpu_reg_file_sb.sv | 111 +++++++++++
 tb/tb_cpu_reg_file_sb.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the scoreboarded CPU register file: default sizes
// and the init/run state encoding.
package cpu_pkg;

    localparam int DEFAULT_REG_COUNT = 16;
    localparam int DEFAULT_REG_WIDTH = 16;

    typedef enum logic {
        CLEAR,
        RUN
    } rf_state_e;

endpackage

// File: rtl/cpu_reg_file_read_port.sv
// One combinational read port: zero-register check, same-cycle write forwarding
// (lowest write port wins among bypass-enabled ports) and readiness from the busy bit.
module cpu_reg_file_read_port
    import cpu_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = 4,
    parameter int                     REG_WIDTH   = DEFAULT_REG_WIDTH,
    parameter int                     WRITE_PORTS = 2,
    parameter logic [WRITE_PORTS-1:0] BYPASS_MASK = '1
) (
    input  logic                              run,
    input  logic [ADDR_WIDTH-1:0]             addr,
    input  logic [REG_WIDTH-1:0]              stored_value,
    input  logic                              stored_busy,
    input  logic [WRITE_PORTS-1:0]            wr_en,
    input  logic [WRITE_PORTS-1:0]            wr_release,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] wr_addr,
    input  logic [WRITE_PORTS*REG_WIDTH-1:0]  wr_data,
    output logic [REG_WIDTH-1:0]              value,
    output logic                              ready
);

    logic [REG_WIDTH-1:0] fwd_data;
    logic                 fwd_release;

    // Walk from the highest index down so the lowest matching port has the final say.
    always_comb begin
        fwd_data    = stored_value;
        fwd_release = 1'b0;
        for (int w = WRITE_PORTS - 1; w >= 0; w--) begin
            if (BYPASS_MASK[w] && wr_en[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] == addr)) begin
                fwd_data    = wr_data[w*REG_WIDTH +: REG_WIDTH];
                fwd_release = wr_release[w];
            end
        end
    end

    always_comb begin
        value = '0;
        ready = 1'b0;
        if (run) begin
            if (addr == '0) begin
                ready = 1'b1;
            end else begin
                value = fwd_data;
                ready = !stored_busy || fwd_release;
            end
        end
    end

endmodule

// File: rtl/cpu_reg_file_sb.sv
// Multi-ported register file with a per-register busy scoreboard. After reset
// it walks every register to zero before accepting reads, writes and claims.
module cpu_reg_file_sb
    import cpu_pkg::*;
#(
    parameter int                     REG_COUNT   = DEFAULT_REG_COUNT,
    parameter int                     REG_WIDTH   = DEFAULT_REG_WIDTH,
    parameter int                     READ_PORTS  = 2,
    parameter int                     WRITE_PORTS = 2,
    parameter logic [WRITE_PORTS-1:0] BYPASS_MASK = '1,
    localparam int                    ADDR_WIDTH  = $clog2(REG_COUNT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0]  rs_addr,
    output logic [READ_PORTS*REG_WIDTH-1:0]   rs_value,
    output logic [READ_PORTS-1:0]             rs_ready,
    input  logic [WRITE_PORTS-1:0]            wr_en,
    input  logic [WRITE_PORTS*ADDR_WIDTH-1:0] wr_addr,
    input  logic [WRITE_PORTS*REG_WIDTH-1:0]  wr_data,
    input  logic [WRITE_PORTS-1:0]            wr_release,
    input  logic                              claim_en,
    input  logic [ADDR_WIDTH-1:0]             claim_addr,
    output logic                              init_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REG_COUNT - 1);

    rf_state_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                  init_done_q, init_done_d;
    logic [REG_WIDTH-1:0]  regs_q [REG_COUNT];
    logic [REG_WIDTH-1:0]  regs_d [REG_COUNT];
    logic [REG_COUNT-1:0]  busy_q, busy_d;
    logic                  run;

    // Reads are suppressed while reset is held so outputs match the CLEAR state at once.
    assign run       = (state_q == RUN) && !rst;
    assign init_done = init_done_q && !rst;

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        regs_d      = regs_q;
        busy_d      = busy_q;
        if (state_q == CLEAR) begin
            regs_d[clr_cnt_q] = '0;
            busy_d[clr_cnt_q] = 1'b0;
            clr_cnt_d         = clr_cnt_q + 1'b1;
            if (clr_cnt_q == LAST_ADDR) begin
                state_d     = RUN;
                init_done_d = 1'b1;
            end
        end else begin
            for (int w = WRITE_PORTS - 1; w >= 0; w--) begin
                if (wr_en[w] && (wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH] != '0)) begin
                    regs_d[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = wr_data[w*REG_WIDTH +: REG_WIDTH];
                end
            end
            for (int w = 0; w < WRITE_PORTS; w++) begin
                if (wr_en[w] && wr_release[w]) begin
                    busy_d[wr_addr[w*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
                end
            end
            // Applied after releases so a colliding claim leaves the register pending.
            if (claim_en && (claim_addr != '0)) begin
                busy_d[claim_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= CLEAR;
            clr_cnt_q   <= ADDR_WIDTH'(1);
            init_done_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            regs_q      <= regs_d;
            busy_q      <= busy_d;
        end
    end

    for (genvar r = 0; r < READ_PORTS; r++) begin : g_read
        logic [ADDR_WIDTH-1:0] rd_addr;
        assign rd_addr = rs_addr[r*ADDR_WIDTH +: ADDR_WIDTH];

        cpu_reg_file_read_port #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .REG_WIDTH  (REG_WIDTH),
            .WRITE_PORTS(WRITE_PORTS),
            .BYPASS_MASK(BYPASS_MASK)
        ) u_port (
            .run         (run),
            .addr        (rd_addr),
            .stored_value(regs_q[rd_addr]),
            .stored_busy (busy_q[rd_addr]),
            .wr_en       (wr_en),
            .wr_release  (wr_release),
            .wr_addr     (wr_addr),
            .wr_data     (wr_data),
            .value       (rs_value[r*REG_WIDTH +: REG_WIDTH]),
            .ready       (rs_ready[r])
        );
    end

endmodule

// File: tb/tb_cpu_reg_file_sb.sv
// Scoreboard bench: two register files (full bypass and BYPASS_MASK=2'b10) share
// one stimulus stream; expected reads are queued and checked on the falling edge.
module tb_cpu_reg_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rs_addr;
    logic [1:0]  wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  wr_release;
    logic        claim_en;
    logic [3:0]  claim_addr;

    logic [31:0] rs_value_a, rs_value_b;
    logic [1:0]  rs_ready_a, rs_ready_b;
    logic        init_done_a, init_done_b;

    always #5 clk = ~clk;

    cpu_reg_file_sb dut_a (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_value(rs_value_a), .rs_ready(rs_ready_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_release(wr_release),
        .claim_en(claim_en), .claim_addr(claim_addr), .init_done(init_done_a)
    );

    cpu_reg_file_sb #(.BYPASS_MASK(2'b10)) dut_b (
        .clk(clk), .rst(rst), .rs_addr(rs_addr), .rs_value(rs_value_b), .rs_ready(rs_ready_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_release(wr_release),
        .claim_en(claim_en), .claim_addr(claim_addr), .init_done(init_done_b)
    );

    typedef struct {
        int          dut;
        int          kind;
        int          port;
        logic [15:0] value;
        logic        ready;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic applyStimulus(input logic [1:0] en, input logic [3:0] wa0, input logic [15:0] wd0,
                                 input logic [3:0] wa1, input logic [15:0] wd1, input logic [1:0] rel,
                                 input logic cl, input logic [3:0] ca, input logic [3:0] ra0,
                                 input logic [3:0] ra1);
        @(posedge clk);
        #1;
        wr_en      = en;
        wr_addr    = {wa1, wa0};
        wr_data    = {wd1, wd0};
        wr_release = rel;
        claim_en   = cl;
        claim_addr = ca;
        rs_addr    = {ra1, ra0};
    endtask

    task automatic idleRead(input logic [3:0] ra0, input logic [3:0] ra1);
        applyStimulus(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, ra0, ra1);
    endtask

    task automatic expectRead(input int dut, input int port, input logic [15:0] v, input logic r,
                              input string name);
        exp_t e;
        e.dut = dut; e.kind = 0; e.port = port; e.value = v; e.ready = r; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic expectBoth(input int port, input logic [15:0] va, input logic ra,
                              input logic [15:0] vb, input logic rb, input string name);
        expectRead(0, port, va, ra, name);
        expectRead(1, port, vb, rb, name);
    endtask

    task automatic expectInit(input logic v, input string name);
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            e.dut = d; e.kind = 1; e.port = 0; e.value = {15'd0, v}; e.ready = 1'b0; e.name = name;
            sb_q.push_back(e);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [15:0] act_v;
        logic        act_r;
        checks++;
        if (e.kind == 1) begin
            act_r = (e.dut == 0) ? init_done_a : init_done_b;
            if (act_r !== e.value[0]) begin
                failures++;
                $display("[TB] FAIL %s dut%0d init_done: got %b expected %b", e.name, e.dut, act_r, e.value[0]);
            end
        end else begin
            act_v = (e.dut == 0) ? rs_value_a[e.port*16 +: 16] : rs_value_b[e.port*16 +: 16];
            act_r = (e.dut == 0) ? rs_ready_a[e.port] : rs_ready_b[e.port];
            if (act_v !== e.value || act_r !== e.ready) begin
                failures++;
                $display("[TB] FAIL %s dut%0d port%0d: got value=%h ready=%b expected value=%h ready=%b",
                         e.name, e.dut, e.port, act_v, act_r, e.value, e.ready);
            end
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checkOutput(e);
        end
    end

    initial begin
        rst = 1'b1;
        wr_en = '0; wr_addr = '0; wr_data = '0; wr_release = '0;
        claim_en = 1'b0; claim_addr = '0; rs_addr = '0;

        // Reset held: CLEAR-state outputs.
        idleRead(4'd0, 4'd5);
        expectBoth(0, 16'h0, 1'b0, 16'h0, 1'b0, "rst_r0");
        expectBoth(1, 16'h0, 1'b0, 16'h0, 1'b0, "rst_r5");
        expectInit(1'b0, "rst_init");

        for (int i = 1; i <= 15; i++) begin
            idleRead(4'd0, 4'd5);
            rst = 1'b0;
            expectInit(1'b0, "clear_init");
            if (i == 1 || i == 15) begin
                expectBoth(0, 16'h0, 1'b0, 16'h0, 1'b0, "clear_r0");
                expectBoth(1, 16'h0, 1'b0, 16'h0, 1'b0, "clear_r5");
            end
        end

        idleRead(4'd0, 4'd15);
        expectInit(1'b1, "init_done");
        expectBoth(0, 16'h0, 1'b1, 16'h0, 1'b1, "init_r0");
        expectBoth(1, 16'h0, 1'b1, 16'h0, 1'b1, "init_r15");

        // Write priority on r5.
        applyStimulus(2'b11, 4'd5, 16'h1111, 4'd5, 16'h2222, 2'b00, 1'b0, 4'd0, 4'd5, 4'd5);
        expectBoth(0, 16'h1111, 1'b1, 16'h2222, 1'b1, "prio_fwd0");
        expectBoth(1, 16'h1111, 1'b1, 16'h2222, 1'b1, "prio_fwd1");
        idleRead(4'd5, 4'd3);
        expectBoth(0, 16'h1111, 1'b1, 16'h1111, 1'b1, "prio_stored");
        expectBoth(1, 16'h0000, 1'b1, 16'h0000, 1'b1, "r3_cleared");

        // Bypass mask on r3.
        applyStimulus(2'b01, 4'd3, 16'hAAAA, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 4'd3, 4'd3);
        expectBoth(0, 16'hAAAA, 1'b1, 16'h0000, 1'b1, "mask_p0");
        expectBoth(1, 16'hAAAA, 1'b1, 16'h0000, 1'b1, "mask_p0b");
        idleRead(4'd3, 4'd3);
        expectBoth(0, 16'hAAAA, 1'b1, 16'hAAAA, 1'b1, "mask_stored");
        applyStimulus(2'b10, 4'd0, 16'h0, 4'd3, 16'h5555, 2'b00, 1'b0, 4'd0, 4'd3, 4'd5);
        expectBoth(0, 16'h5555, 1'b1, 16'h5555, 1'b1, "mask_p1");
        expectBoth(1, 16'h1111, 1'b1, 16'h1111, 1'b1, "mask_other");
        idleRead(4'd3, 4'd3);
        expectBoth(0, 16'h5555, 1'b1, 16'h5555, 1'b1, "mask_p1_stored");

        // Claim r7, then release it through port 1.
        applyStimulus(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd7, 4'd7, 4'd0);
        expectBoth(0, 16'h0, 1'b1, 16'h0, 1'b1, "claim_same");
        idleRead(4'd7, 4'd7);
        expectBoth(0, 16'h0, 1'b0, 16'h0, 1'b0, "claim_busy");
        applyStimulus(2'b10, 4'd0, 16'h0, 4'd7, 16'h0042, 2'b10, 1'b0, 4'd0, 4'd7, 4'd7);
        expectBoth(0, 16'h0042, 1'b1, 16'h0042, 1'b1, "release_fwd");
        expectBoth(1, 16'h0042, 1'b1, 16'h0042, 1'b1, "release_fwd1");
        idleRead(4'd7, 4'd7);
        expectBoth(0, 16'h0042, 1'b1, 16'h0042, 1'b1, "release_after");

        // Claim r8; write without release, release without enable, then real release on port 0.
        applyStimulus(2'b00, 4'd0, 16'h0, 4'd0, 16'h0, 2'b00, 1'b1, 4'd8, 4'd8, 4'd7);
        expectBoth(0, 16'h0, 1'b1, 16'h0, 1'b1, "claim8_same");
        applyStimulus(2'b01, 4'd8, 16'h0101, 4'd0, 16'h0, 2'b00, 1'b0, 4'd0, 4'd8, 4'd8);
        expectBoth(0, 16'h0101, 1'b0, 16'h0000, 1'b0, "wr_norel");
        applyStimulus(2'b00, 4'd8, 16'h0, 4'd0, 16'h0, 2'b01, 1'b0, 4'd0, 4'd8, 4'd8);
        expectBoth(0, 16'h0101, 1'b0, 16'h0101, 1'b0, "rel_noen");
        idleRead(4'd8, 4'd8);
        expectBoth(1, 16'h0101, 1'b0, 16'h0101, 1'b0, "still_busy");
        applyStimulus(2'b01, 4'd8, 16'h0202, 4'd0, 16'h0, 2'b01, 1'b0, 4'd0, 4'd8, 4'd8);
        expectBoth(0, 16'h0202, 1'b1, 16'h0101, 1'b0, "rel_p0");
        idleRead(4'd8, 4'd8);
        expectBoth(0, 16'h0202, 1'b1, 16'h0202, 1'b1, "rel_p0_after");

        // Claim and release of r9 collide.
        applyStimulus(2'b01, 4'd9, 16'h9999, 4'd0, 16'h0, 2'b01, 1'b1, 4'd9, 4'd9, 4'd9);
        expectBoth(0, 16'h9999, 1'b1, 16'h0000, 1'b1, "collide_same");
        idleRead(4'd9, 4'd9);
        expectBoth(0, 16'h9999, 1'b0, 16'h9999, 1'b0, "collide_after");

        // Register 0 ignores writes and claims.
        applyStimulus(2'b01, 4'd0, 16'hFFFF, 4'd0, 16'h0, 2'b00, 1'b1, 4'd0, 4'd0, 4'd0);
        expectBoth(0, 16'h0, 1'b1, 16'h0, 1'b1, "r0_write_same");
        idleRead(4'd0, 4'd9);
        expectBoth(0, 16'h0, 1'b1, 16'h0, 1'b1, "r0_write_after");
        expectBoth(1, 16'h9999, 1'b0, 16'h9999, 1'b0, "r9_busy");

        // Reset mid-operation.
        applyStimulus(2'b01, 4'd2, 16'hBEEF, 4'd0, 16'h0, 2'b00, 1'b1, 4'd4, 4'd2, 4'd4);
        expectBoth(0, 16'hBEEF, 1'b1, 16'h0000, 1'b1, "r2_write");
        expectBoth(1, 16'h0000, 1'b1, 16'h0000, 1'b1, "r4_claim_same");
        idleRead(4'd2, 4'd4);
        expectBoth(0, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1, "r2_stored");
        expectBoth(1, 16'h0000, 1'b0, 16'h0000, 1'b0, "r4_busy");
        idleRead(4'd2, 4'd4);
        rst = 1'b1;
        expectInit(1'b0, "mid_rst_init");
        expectBoth(0, 16'h0, 1'b0, 16'h0, 1'b0, "mid_rst_r2");
        expectBoth(1, 16'h0, 1'b0, 16'h0, 1'b0, "mid_rst_r4");

        for (int i = 1; i <= 15; i++) begin
            if (i == 15) begin
                applyStimulus(2'b01, 4'd2, 16'h1234, 4'd0, 16'h0, 2'b00, 1'b1, 4'd6, 4'd2, 4'd4);
            end else begin
                idleRead(4'd2, 4'd4);
            end
            rst = 1'b0;
            expectInit(1'b0, "reclear_init");
            if (i == 1 || i == 15) begin
                expectBoth(0, 16'h0, 1'b0, 16'h0, 1'b0, "reclear_r2");
                expectBoth(1, 16'h0, 1'b0, 16'h0, 1'b0, "reclear_r4");
            end
        end

        idleRead(4'd2, 4'd4);
        expectInit(1'b1, "reinit_done");
        expectBoth(0, 16'h0, 1'b1, 16'h0, 1'b1, "reinit_r2");
        expectBoth(1, 16'h0, 1'b1, 16'h0, 1'b1, "reinit_r4");
        idleRead(4'd6, 4'd9);
        expectBoth(0, 16'h0, 1'b1, 16'h0, 1'b1, "clear_ignored_claim");
        expectBoth(1, 16'h0, 1'b1, 16'h0, 1'b1, "reinit_r9");

        idleRead(4'd0, 4'd0);
        @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
